// File: rtl/id_stage_pipelined_if.sv
// Handshake and data bundle between IF/WB/hazard logic and the decode stage.
// The slave side is the decode stage; the master side drives instructions and consumes ID/EXE.
interface id_stage_pipelined_if #(
   parameter int DATA_W      = 32,
   parameter int REG_AW      = 5,
   parameter int STALL_CNT_W = 16
);
   logic                   in_valid;
   logic                   in_ready;
   logic [31:0]            instruction;
   logic                   hazard_detected;
   logic                   flush;
   logic                   wb_en_in;
   logic [REG_AW-1:0]      wb_dest;
   logic [DATA_W-1:0]      wb_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [REG_AW-1:0]      dest;
   logic [REG_AW-1:0]      src1;
   logic [REG_AW-1:0]      src2;
   logic [DATA_W-1:0]      val1;
   logic [DATA_W-1:0]      val2;
   logic [DATA_W-1:0]      reg2;
   logic [3:0]             exe_cmd;
   logic [1:0]             br_type;
   logic                   mem_r_en;
   logic                   mem_w_en;
   logic                   wb_en;
   logic                   single_src;
   logic [STALL_CNT_W-1:0] stall_count;

   modport master (
      output in_valid, instruction, hazard_detected, flush,
             wb_en_in, wb_dest, wb_data, out_ready,
      input  in_ready, out_valid, dest, src1, src2, val1, val2, reg2,
             exe_cmd, br_type, mem_r_en, mem_w_en, wb_en, single_src, stall_count
   );

   modport slave (
      input  in_valid, instruction, hazard_detected, flush,
             wb_en_in, wb_dest, wb_data, out_ready,
      output in_ready, out_valid, dest, src1, src2, val1, val2, reg2,
             exe_cmd, br_type, mem_r_en, mem_w_en, wb_en, single_src, stall_count
   );
endinterface

// File: rtl/id_stage_pipelined.sv
// MIPS decode stage: control decode, bypassed register-file reads, operand select and a
// valid/ready ID/EXE register with hazard bubbles, flush and a saturating stall counter.
module id_stage_pipelined #(
   parameter int DATA_W         = 32,
   parameter int REG_COUNT      = 32,
   parameter int ZERO_EXT_LOGIC = 0,
   parameter int STALL_CNT_W    = 16
) (
   input logic                 clk,
   input logic                 rst,
   id_stage_pipelined_if.slave bus
);
   localparam int REG_AW = $clog2(REG_COUNT);

   localparam logic [5:0] OP_NOP  = 6'd0,  OP_ADD  = 6'd1,  OP_SUB  = 6'd3,  OP_AND  = 6'd5;
   localparam logic [5:0] OP_OR   = 6'd6,  OP_NOR  = 6'd7,  OP_XOR  = 6'd8,  OP_SLA  = 6'd9;
   localparam logic [5:0] OP_SLL  = 6'd10, OP_SRA  = 6'd11, OP_SRL  = 6'd12, OP_ADDI = 6'd32;
   localparam logic [5:0] OP_SUBI = 6'd33, OP_ANDI = 6'd34, OP_ORI  = 6'd35, OP_LD   = 6'd36;
   localparam logic [5:0] OP_ST   = 6'd37, OP_XORI = 6'd38, OP_BEZ  = 6'd40, OP_BNE  = 6'd41;
   localparam logic [5:0] OP_JMP  = 6'd42;

   // Logical ALU commands share the 01xx prefix, which the extension select relies on.
   localparam logic [3:0] EX_ADD = 4'b0000, EX_SUB = 4'b0010, EX_AND = 4'b0100, EX_OR  = 4'b0101;
   localparam logic [3:0] EX_NOR = 4'b0110, EX_XOR = 4'b0111, EX_SLL = 4'b1000, EX_SRA = 4'b1001;
   localparam logic [3:0] EX_SRL = 4'b1010;

   localparam logic [1:0] BR_NONE = 2'd0, BR_BEZ = 2'd1, BR_BNE = 2'd2, BR_JMP = 2'd3;

   typedef struct packed {
      logic [3:0] exe_cmd;
      logic [1:0] br_type;
      logic       mem_r_en;
      logic       mem_w_en;
      logic       wb_en;
      logic       single_src;
      logic       is_imm;
   } ctrl_t;

   typedef struct packed {
      logic [REG_AW-1:0] dest;
      logic [REG_AW-1:0] src1;
      logic [REG_AW-1:0] src2;
      logic [DATA_W-1:0] val1;
      logic [DATA_W-1:0] val2;
      logic [DATA_W-1:0] reg2;
      logic [3:0]        exe_cmd;
      logic [1:0]        br_type;
      logic              mem_r_en;
      logic              mem_w_en;
      logic              wb_en;
      logic              single_src;
   } idex_t;

   function automatic ctrl_t ctl(input logic [3:0] exe, input logic [1:0] br,
                                 input logic mr, input logic mw, input logic wb,
                                 input logic ss, input logic imm);
      ctrl_t c;
      c.exe_cmd    = exe;
      c.br_type    = br;
      c.mem_r_en   = mr;
      c.mem_w_en   = mw;
      c.wb_en      = wb;
      c.single_src = ss;
      c.is_imm     = imm;
      return c;
   endfunction

   logic [DATA_W-1:0]      r_rf [REG_COUNT];
   idex_t                  r_idex;
   logic                   r_out_valid;
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   logic [5:0]        w_opcode;
   logic [4:0]        w_rs, w_rt, w_rd;
   logic [15:0]       w_imm;
   logic [REG_AW-1:0] w_src1, w_src2, w_dest;
   logic [DATA_W-1:0] w_val1, w_reg2, w_imm_ext;
   logic              w_zext, w_wb_hit, w_adv;
   ctrl_t             w_ctrl;
   idex_t             w_next;

   assign w_opcode = bus.instruction[31:26];
   assign w_rs     = bus.instruction[25:21];
   assign w_rt     = bus.instruction[20:16];
   assign w_rd     = bus.instruction[15:11];
   assign w_imm    = bus.instruction[15:0];

   // single_src marks branches that read only src1 (or no register at all).
   always_comb begin
      w_ctrl = '0;
      case (w_opcode)
         OP_NOP  : w_ctrl = '0;
         OP_ADD  : w_ctrl = ctl(EX_ADD, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         OP_SUB  : w_ctrl = ctl(EX_SUB, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         OP_AND  : w_ctrl = ctl(EX_AND, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         OP_OR   : w_ctrl = ctl(EX_OR,  BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         OP_NOR  : w_ctrl = ctl(EX_NOR, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         OP_XOR  : w_ctrl = ctl(EX_XOR, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         OP_SLA  : w_ctrl = ctl(EX_SLL, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         OP_SLL  : w_ctrl = ctl(EX_SLL, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         OP_SRA  : w_ctrl = ctl(EX_SRA, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         OP_SRL  : w_ctrl = ctl(EX_SRL, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         OP_ADDI : w_ctrl = ctl(EX_ADD, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
         OP_SUBI : w_ctrl = ctl(EX_SUB, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
         OP_ANDI : w_ctrl = ctl(EX_AND, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
         OP_ORI  : w_ctrl = ctl(EX_OR,  BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
         OP_XORI : w_ctrl = ctl(EX_XOR, BR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
         OP_LD   : w_ctrl = ctl(EX_ADD, BR_NONE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
         OP_ST   : w_ctrl = ctl(EX_ADD, BR_NONE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
         OP_BEZ  : w_ctrl = ctl(EX_ADD, BR_BEZ,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         OP_BNE  : w_ctrl = ctl(EX_ADD, BR_BNE,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         OP_JMP  : w_ctrl = ctl(EX_ADD, BR_JMP,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         default : w_ctrl = '0;
      endcase
   end

   assign w_src1 = REG_AW'(w_rs);
   assign w_src2 = REG_AW'(w_rt);
   assign w_dest = w_ctrl.is_imm ? REG_AW'(w_rt) : REG_AW'(w_rd);

   assign w_wb_hit = bus.wb_en_in && (bus.wb_dest != '0);

   // Same-cycle write-back is forwarded so a decode never sees a stale value.
   always_comb begin
      w_val1 = r_rf[w_src1];
      if (w_wb_hit && (bus.wb_dest == w_src1)) w_val1 = bus.wb_data;
      if (w_src1 == '0) w_val1 = '0;
      w_reg2 = r_rf[w_src2];
      if (w_wb_hit && (bus.wb_dest == w_src2)) w_reg2 = bus.wb_data;
      if (w_src2 == '0) w_reg2 = '0;
   end

   assign w_zext    = (ZERO_EXT_LOGIC != 0) && (w_ctrl.exe_cmd[3:2] == 2'b01);
   assign w_imm_ext = w_zext ? DATA_W'(w_imm) : DATA_W'($signed(w_imm));

   always_comb begin
      w_next            = '0;
      w_next.dest       = w_dest;
      w_next.src1       = w_src1;
      w_next.src2       = w_src2;
      w_next.val1       = w_val1;
      w_next.val2       = w_ctrl.is_imm ? w_imm_ext : w_reg2;
      w_next.reg2       = w_reg2;
      w_next.exe_cmd    = w_ctrl.exe_cmd;
      w_next.br_type    = w_ctrl.br_type;
      w_next.mem_r_en   = w_ctrl.mem_r_en;
      w_next.mem_w_en   = w_ctrl.mem_w_en;
      w_next.wb_en      = w_ctrl.wb_en;
      w_next.single_src = w_ctrl.single_src;
   end

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_COUNT; i++) r_rf[i] <= '0;
      end else if (w_wb_hit) begin
         r_rf[bus.wb_dest] <= bus.wb_data;
      end
   end

   assign w_adv        = !r_out_valid || bus.out_ready;
   assign bus.in_ready = w_adv && !bus.hazard_detected && !bus.flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_valid <= 1'b0;
         r_idex      <= '0;
         r_stall_cnt <= '0;
      end else if (bus.flush) begin
         r_out_valid <= 1'b0;
         r_idex      <= '0;
      end else if (w_adv) begin
         if (bus.hazard_detected && bus.in_valid) begin
            r_out_valid <= 1'b0;
            r_idex      <= '0;
            if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
         end else if (bus.in_valid) begin
            r_out_valid <= 1'b1;
            r_idex      <= w_next;
         end else begin
            r_out_valid <= 1'b0;
            r_idex      <= '0;
         end
      end
   end

   assign bus.out_valid   = r_out_valid;
   assign bus.dest        = r_idex.dest;
   assign bus.src1        = r_idex.src1;
   assign bus.src2        = r_idex.src2;
   assign bus.val1        = r_idex.val1;
   assign bus.val2        = r_idex.val2;
   assign bus.reg2        = r_idex.reg2;
   assign bus.exe_cmd     = r_idex.exe_cmd;
   assign bus.br_type     = r_idex.br_type;
   assign bus.mem_r_en    = r_idex.mem_r_en;
   assign bus.mem_w_en    = r_idex.mem_w_en;
   assign bus.wb_en       = r_idex.wb_en;
   assign bus.single_src  = r_idex.single_src;
   assign bus.stall_count = r_stall_cnt;
endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined: expected ID/EXE words are queued at issue time and
// popped by a monitor on every transfer; state checks cover reset, stalls, flush and backpressure.
module tb_id_stage_pipelined;
   localparam logic [5:0] OP_ADD = 6'd1,  OP_SUB = 6'd3,  OP_AND = 6'd5,  OP_NOR = 6'd7;
   localparam logic [5:0] OP_XOR = 6'd8,  OP_ADDI = 6'd32, OP_ORI = 6'd35, OP_LD = 6'd36;
   localparam logic [5:0] OP_ST  = 6'd37, OP_BEZ = 6'd40;
   localparam logic [3:0] EX_ADD = 4'b0000, EX_SUB = 4'b0010, EX_AND = 4'b0100;
   localparam logic [3:0] EX_OR  = 4'b0101, EX_XOR = 4'b0111;

   typedef struct packed {
      logic [4:0]  dest;
      logic [4:0]  src1;
      logic [4:0]  src2;
      logic [31:0] val1;
      logic [31:0] val2;
      logic [31:0] reg2;
      logic [3:0]  exe;
      logic [1:0]  br;
      logic        mr;
      logic        mw;
      logic        wb;
      logic        ss;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t q[$];
   exp_t a_exp, b_exp;

   always #5 clk = ~clk;

   id_stage_pipelined_if #(.DATA_W(32), .REG_AW(5), .STALL_CNT_W(2)) bus ();

   id_stage_pipelined #(
      .DATA_W(32), .REG_COUNT(32), .ZERO_EXT_LOGIC(1), .STALL_CNT_W(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
      return {op, rs, rt, rd, 11'd0};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic exp_t mk(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                               input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] r2,
                               input logic [3:0] ex, input logic [1:0] br, input logic mr,
                               input logic mw, input logic wb, input logic ss);
      exp_t e;
      e.dest = d;  e.src1 = s1; e.src2 = s2;
      e.val1 = v1; e.val2 = v2; e.reg2 = r2;
      e.exe  = ex; e.br   = br; e.mr   = mr; e.mw = mw; e.wb = wb; e.ss = ss;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] instr, input exp_t e);
      bus.in_valid    = 1'b1;
      bus.instruction = instr;
      q.push_back(e);
      tick();
      bus.in_valid    = 1'b0;
   endtask

   // Every transfer to EXE must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t act, e;
      if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         act = {bus.dest, bus.src1, bus.src2, bus.val1, bus.val2, bus.reg2,
                bus.exe_cmd, bus.br_type, bus.mem_r_en, bus.mem_w_en, bus.wb_en, bus.single_src};
         n_tests++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got %h, required no transfer", act);
         end else begin
            e = q.pop_front();
            if (act !== e) begin
               n_fail++;
               $display("FAIL sb_transfer: got %h, required %h", act, e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst                 = 1'b0;
      bus.in_valid        = 1'b0;
      bus.instruction     = '0;
      bus.hazard_detected = 1'b0;
      bus.flush           = 1'b0;
      bus.wb_en_in        = 1'b0;
      bus.wb_dest         = '0;
      bus.wb_data         = '0;
      bus.out_ready       = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_stall", 64'(bus.stall_count), 64'd0);
      chk("rst_wb_en", 64'(bus.wb_en), 64'd0);
      chk("rst_val1", 64'(bus.val1), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      rst = 1'b1;

      // write-back then read
      bus.wb_en_in = 1'b1; bus.wb_dest = 5'd5; bus.wb_data = 32'h0000_1234;
      tick();
      bus.wb_en_in = 1'b0;
      send(rtype(OP_ADD, 5'd5, 5'd5, 5'd3),
           mk(5'd3, 5'd5, 5'd5, 32'h1234, 32'h1234, 32'h1234, EX_ADD, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      chk("lat_out_valid", 64'(bus.out_valid), 64'd1);

      // same-cycle bypass, then r0 write ignored
      bus.wb_en_in = 1'b1; bus.wb_dest = 5'd7; bus.wb_data = 32'hDEAD_BEEF;
      send(rtype(OP_ADD, 5'd7, 5'd0, 5'd1),
           mk(5'd1, 5'd7, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, EX_ADD, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      bus.wb_dest = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
      send(rtype(OP_ADD, 5'd0, 5'd7, 5'd2),
           mk(5'd2, 5'd0, 5'd7, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, EX_ADD, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      bus.wb_en_in = 1'b0;
      send(rtype(OP_ADD, 5'd0, 5'd0, 5'd4),
           mk(5'd4, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, EX_ADD, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));

      // immediates, memory ops, branch
      send(itype(OP_ADDI, 5'd5, 5'd9, 16'h8000),
           mk(5'd9, 5'd5, 5'd9, 32'h1234, 32'hFFFF_8000, 32'h0, EX_ADD, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      send(itype(OP_ORI, 5'd5, 5'd10, 16'h8000),
           mk(5'd10, 5'd5, 5'd10, 32'h1234, 32'h0000_8000, 32'h0, EX_OR, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      send(itype(OP_LD, 5'd5, 5'd11, 16'h0004),
           mk(5'd11, 5'd5, 5'd11, 32'h1234, 32'h4, 32'h0, EX_ADD, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0));
      send(itype(OP_ST, 5'd5, 5'd7, 16'h0008),
           mk(5'd7, 5'd5, 5'd7, 32'h1234, 32'h8, 32'hDEAD_BEEF, EX_ADD, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
      send(itype(OP_BEZ, 5'd5, 5'd0, 16'hFFFE),
           mk(5'd0, 5'd5, 5'd0, 32'h1234, 32'hFFFF_FFFE, 32'h0, EX_ADD, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1));
      tick();

      // backpressure: A held for 3 cycles while B waits
      bus.out_ready = 1'b0;
      a_exp = mk(5'd6, 5'd5, 5'd7, 32'h1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, EX_SUB, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      b_exp = mk(5'd8, 5'd5, 5'd7, 32'h1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, EX_XOR, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      send(rtype(OP_SUB, 5'd5, 5'd7, 5'd6), a_exp);
      bus.in_valid    = 1'b1;
      bus.instruction = rtype(OP_XOR, 5'd5, 5'd7, 5'd8);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
         chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
         chk("bp_hold", 64'({bus.dest, bus.exe_cmd, bus.val2}), 64'({a_exp.dest, a_exp.exe, a_exp.val2}));
         tick();
      end
      bus.out_ready = 1'b1;
      q.push_back(b_exp);
      #1;
      chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
      tick();
      bus.in_valid = 1'b0;
      chk("bp_next_loaded", 64'({bus.out_valid, bus.exe_cmd, bus.dest}), 64'({1'b1, EX_XOR, 5'd8}));
      tick();

      // hazard bubbles, then issue on release
      bus.hazard_detected = 1'b1;
      bus.in_valid        = 1'b1;
      bus.instruction     = rtype(OP_AND, 5'd5, 5'd7, 5'd12);
      #1;
      chk("hz_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      chk("hz_out_valid", 64'(bus.out_valid), 64'd0);
      chk("hz_ctrl", 64'({bus.wb_en, bus.mem_r_en, bus.mem_w_en, bus.exe_cmd, bus.br_type, bus.single_src}), 64'd0);
      chk("hz_stall1", 64'(bus.stall_count), 64'd1);
      tick();
      chk("hz_out_valid2", 64'(bus.out_valid), 64'd0);
      chk("hz_stall2", 64'(bus.stall_count), 64'd2);
      bus.hazard_detected = 1'b0;
      q.push_back(mk(5'd12, 5'd5, 5'd7, 32'h1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, EX_AND, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      #1;
      chk("hz_release_ready", 64'(bus.in_ready), 64'd1);
      tick();
      chk("hz_issue_valid", 64'(bus.out_valid), 64'd1);
      bus.hazard_detected = 1'b1;
      for (int k = 3; k <= 5; k++) begin
         tick();
         chk("hz_saturate", 64'(bus.stall_count), 64'd3);
      end
      bus.hazard_detected = 1'b0;
      bus.in_valid        = 1'b0;
      tick();

      // flush while held under backpressure
      bus.out_ready   = 1'b0;
      bus.in_valid    = 1'b1;
      bus.instruction = rtype(OP_NOR, 5'd5, 5'd7, 5'd13);
      tick();
      chk("fl_held_valid", 64'(bus.out_valid), 64'd1);
      bus.flush       = 1'b1;
      bus.instruction = rtype(OP_ADD, 5'd5, 5'd5, 5'd14);
      #1;
      chk("fl_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
      chk("fl_wb_en", 64'(bus.wb_en), 64'd0);
      tick();
      chk("fl_not_accepted", 64'(bus.out_valid), 64'd0);

      // asynchronous reset mid-transfer
      bus.in_valid    = 1'b1;
      bus.instruction = rtype(OP_ADD, 5'd5, 5'd7, 5'd15);
      tick();
      bus.in_valid = 1'b0;
      chk("rs_held_valid", 64'(bus.out_valid), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("rs_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rs_fields", 64'({bus.dest, bus.val1[15:0], bus.wb_en}), 64'd0);
      chk("rs_stall", 64'(bus.stall_count), 64'd0);
      #1 rst = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      send(rtype(OP_ADD, 5'd5, 5'd7, 5'd1),
           mk(5'd1, 5'd5, 5'd7, 32'h0, 32'h0, 32'h0, EX_ADD, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      tick();
      tick();
      chk("sb_drained", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
